// File: rtl/kronos_iresp_pkg.sv
// Shared types and constants for the kronos instruction-bus responder.
// The stall injector is built only when KRONOS_IRESP_RANDSTALL_EN is defined.
package kronos_iresp_pkg;

    typedef enum logic [1:0] {
        IRESP_IDLE = 2'd0,
        IRESP_WAIT = 2'd1,
        IRESP_RESP = 2'd2
    } iresp_state_t;

    localparam logic [31:0] IRESP_NOP = 32'h0000_0013;

    // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
    localparam logic [15:0] IRESP_LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] iresp_lfsr_next(input logic [15:0] s);
        return {^(s & IRESP_LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/kronos_iresp_mem.sv
// 1R1W synchronous instruction RAM, DEPTH x 32, read-before-write on collision.
// The read register resets to zero; the array itself is not reset.
module kronos_iresp_mem
    import kronos_iresp_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data
);

    logic [31:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_addr] <= wr_data;
        end
    end

    // Both blocks sample the array before the edge, so a same-cycle read sees old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= ram[rd_addr];
        end
    end

endmodule

// File: rtl/kronos_instr_responder.sv
// Memory-side responder for the kronos_core instruction bus with wait states and abort.
// Define KRONOS_IRESP_RANDSTALL_EN to add LFSR-driven pseudo-random stall cycles.
module kronos_instr_responder
    import kronos_iresp_pkg::*;
#(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter logic [31:0] DEFAULT_INSTR = IRESP_NOP,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    output logic        err_misaligned,
    output logic [31:0] served_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    iresp_state_t state;
    logic [3:0]   wait_cnt;
    logic         oor_q;
    logic         accept;
    logic         stall;
    logic [4:0]   eff_wait;
    logic         rd_in_range;
    logic         ld_in_range;
    logic [31:0]  mem_rdata;

    assign rd_in_range = (instr_addr >> (AW + 2)) == '0;
    assign ld_in_range = (load_addr  >> (AW + 2)) == '0;
    assign accept      = instr_req && (state == IRESP_IDLE || state == IRESP_RESP);

`ifdef KRONOS_IRESP_RANDSTALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (accept) begin
            lfsr <= iresp_lfsr_next(lfsr);
        end
    end

    assign stall = lfsr[0];
`else
    logic unused_seed;

    assign unused_seed = ^LFSR_SEED;
    assign stall       = 1'b0;
`endif

    assign eff_wait = 5'(WAIT_CYCLES) + {4'b0000, stall};

    kronos_iresp_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (accept && rd_in_range),
        .rd_addr (instr_addr[2 +: AW]),
        .rd_data (mem_rdata),
        .wr_en   (load_en && ld_in_range),
        .wr_addr (load_addr[2 +: AW]),
        .wr_data (load_data)
    );

    // Out-of-range requests skip the RAM read; the latched flag substitutes the default word.
    assign instr_data = oor_q ? DEFAULT_INSTR : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IRESP_IDLE;
            wait_cnt       <= '0;
            instr_ack      <= 1'b0;
            oor_q          <= 1'b0;
            err_misaligned <= 1'b0;
            served_count   <= '0;
        end else begin
            instr_ack <= 1'b0;
            if (accept) begin
                oor_q <= !rd_in_range;
                if (instr_addr[1:0] != 2'b00) begin
                    err_misaligned <= 1'b1;
                end
                if (eff_wait == '0) begin
                    state        <= IRESP_RESP;
                    instr_ack    <= 1'b1;
                    served_count <= served_count + 32'd1;
                end else begin
                    state    <= IRESP_WAIT;
                    wait_cnt <= 4'(eff_wait - 5'd1);
                end
            end else begin
                case (state)
                    IRESP_WAIT: begin
                        if (!instr_req) begin
                            state <= IRESP_IDLE;
                        end else if (wait_cnt == '0) begin
                            state        <= IRESP_RESP;
                            instr_ack    <= 1'b1;
                            served_count <= served_count + 32'd1;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    IRESP_RESP: state <= IRESP_IDLE;
                    default:    state <= IRESP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/kronos_instr_responder.md
# kronos_instr_responder

Instruction-bus responder (memory side) for `kronos_core`: accepts `instr_req`/`instr_addr` from the core's fetch stage and returns `instr_data` with `instr_ack` from an internal word-addressed instruction RAM. It provides programmable wait states, request abort on core flush, and an optional pseudo-random stall injector. It sits between the core and a test or boot program image, which is preloaded through a side load port.

## Interface
- `DEPTH`, 1024: instruction RAM size in 32-bit words; power of two, 2 to 65536.
- `WAIT_CYCLES`, 0: fixed extra latency per request, 0 to 15.
- `DEFAULT_INSTR`, 32'h00000013: data returned for out-of-range addresses (NOP).
- `LFSR_SEED`, 16'hACE1: stall-injector seed; must be nonzero.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_addr`  in  32  byte address from core.
- `instr_req`  in  1  fetch request.
- `instr_data`  out  32  fetched instruction word.
- `instr_ack`  out  1  one-cycle valid strobe for `instr_data`.
- `load_en`  in  1  RAM write strobe.
- `load_addr`  in  32  byte address for load.
- `load_data`  in  32  word to write.
- `err_misaligned`  out  1  sticky flag: a request was accepted with `instr_addr[1:0]` != 0.
- `served_count`  out  32  number of acks issued; wraps at 2^32.

## Operation
- Word index = `addr[2 +: $clog2(DEPTH)]`. An address is out of range if any bit above that field is set. Out-of-range reads return `DEFAULT_INSTR`. Out-of-range loads are dropped.
- States: IDLE, WAIT, RESP.
- IDLE: if `instr_req`=1, latch the address and look up the word.
  - Next state is RESP if the effective wait is 0.
  - Otherwise next state is WAIT, with the counter loaded to the effective wait − 1.
- WAIT: decrement the counter each cycle and go to RESP at 0.
  - If `instr_req`=0 in any WAIT cycle, the request is aborted. Return to IDLE; no ack is issued and `served_count` is unchanged.
- RESP: `instr_ack`=1 and `instr_data` = the latched word for exactly one cycle.
  - If `instr_req`=1 in this cycle, a new request is accepted as it would be from IDLE. This gives back-to-back throughput.
  - Otherwise go to IDLE.
- Effective wait = `WAIT_CYCLES` + stall bit (stall bit is 0 unless the macro is enabled).
- In RESP the ack is issued even if `instr_req` has dropped. The core discards it.
- Misaligned address: the word is still served with the low bits ignored, and `err_misaligned` is set. It clears only on `rst`.
- Load and read of the same word in the same cycle: the read returns the old contents.

## Timing
- Latency:
  - Request sampled at edge t gives `instr_ack` high in cycle t+1+effective_wait.
  - With `WAIT_CYCLES`=0 and stalls off, one ack per cycle for a continuously asserted `instr_req`.
- `instr_data` holds its last value when `instr_ack`=0.
- Reset values: state IDLE, `instr_ack`=0, `instr_data`=0, `err_misaligned`=0, `served_count`=0, LFSR=`LFSR_SEED`, wait counter 0. RAM contents are not reset.
- `rst` asserted mid-request drops the request immediately; no ack follows.

## Configuration
- `KRONOS_IRESP_RANDSTALL_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances once per accepted request.
  - Its bit 0 before the advance is the stall bit for that request.
  - Mimics irregular `instr_ack` behaviour for core stress tests.
- Not defined: no LFSR logic and stall bit is constant 0. Latency is exactly `WAIT_CYCLES`+1.

## Structure
- `kronos_iresp_pkg`: state enum (`IRESP_IDLE`, `IRESP_WAIT`, `IRESP_RESP`), `IRESP_NOP` constant, LFSR tap mask.
- Sub-module `kronos_iresp_mem`: 1R1W synchronous RAM, `DEPTH` x 32, read-before-write on collision. The FSM, counters and LFSR live in the top module.

## Test plan
- Reset, load words 0..3 with 0x00100093, 0x00200113, 0x00300193, 0x00400213. Then hold `instr_req`=1 with addresses 0x0, 0x4, 0x8, 0xC on consecutive cycles, `WAIT_CYCLES`=0 -> four consecutive acks with those words in order; `served_count`=4.
- `WAIT_CYCLES`=3, single request to 0x4 -> ack exactly 4 cycles after sampling, data 0x00200113.
- `WAIT_CYCLES`=3, request to 0x8, drop `instr_req` after 1 cycle -> no ack, FSM back in IDLE, `served_count` unchanged. A following request to 0xC is served normally.
- Request to address `DEPTH`*4 -> data 0x00000013. Request to 0x6 -> data of word 1, `err_misaligned`=1 and stays set.
- Assert `rst` while in WAIT -> `instr_ack` remains 0 and all outputs take reset values.
- With `KRONOS_IRESP_RANDSTALL_EN`, seed 16'hACE1, 32 back-to-back requests -> the ack-gap sequence matches a reference LFSR model, and every data word matches RAM contents.
